lg_eval_arbiter: RTL and testbench

Round-robin controller that shares one 6-input gate-level evaluation core among `N_REQ` requesters. It captures the winning requester's operands into a register and waits a programmable settle interval so the gate delays can resolve. It then samples the core output and returns the result with a one-cycle completion pulse tagged by requester index. It sits between the requesting blocks and the shared combinational gate network.

---
 rtl/lg_eval_pkg.sv | 23 ++
 rtl/lg_eval_core.sv | 18 +
 rtl/lg_eval_arbiter.sv | 126 ++++++++++++
 tb/tb_lg_eval_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lg_eval_pkg.sv
// Shared constants, field positions and FSM encoding for the gate-evaluation arbiter.
package lg_eval_pkg;

  localparam int OPND_W = 6;

  // Operand bit positions, {a,b,c,d,e,f} with a at the MSB
  localparam int A_IDX = 5;
  localparam int B_IDX = 4;
  localparam int C_IDX = 3;
  localparam int D_IDX = 2;
  localparam int E_IDX = 1;
  localparam int F_IDX = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EVAL = 1'b1
  } state_e;

  function automatic int IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lg_eval_core.sv
// Shared 6-input gate network; purely combinational, driven from the captured operand register.
module lg_eval_core
  import lg_eval_pkg::*;
(
  input  logic [OPND_W-1:0] op,
  output logic              y
);

  logic t1;
  logic t2;
  logic t3;

  assign t1 = ~(op[A_IDX] & op[B_IDX]);
  assign t2 = op[C_IDX] & ~op[B_IDX] & op[D_IDX];
  assign t3 = ~(op[E_IDX] | op[F_IDX]);
  assign y  = ~(t1 & t2 & t3);

endmodule

// File: rtl/lg_eval_arbiter.sv
// Round-robin owner of the shared gate core: capture winner operands, wait SETTLE cycles,
// then return the sampled result with a one-cycle done pulse tagged by requester index.
module lg_eval_arbiter
  import lg_eval_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [OPND_W*N_REQ-1:0]    opnd,
  output logic [N_REQ-1:0]           gnt,
  output logic                       done,
  output logic [IDX_W(N_REQ)-1:0]    done_id,
  output logic                       y_out,
  output logic                       busy
);

  localparam int IW = IDX_W(N_REQ);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              done_q, done_d;
  logic [IW-1:0]     done_id_q, done_id_d;
  logic              y_q, y_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OPND_W-1:0] op_q, op_d;

  logic              core_y;
  logic [IW-1:0]     win;

  // First asserted request at or above p, wrapping modulo N_REQ
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic          found;
    int            j;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(p) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        w     = j[IW-1:0];
      end
    end
    return w;
  endfunction

  lg_eval_core u_core (
    .op (op_q),
    .y  (core_y)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    y_d       = y_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    win       = rr_pick(req, ptr_q);

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          op_d       = opnd[int'(win)*OPND_W +: OPND_W];
          idx_d      = win;
          cnt_d      = 4'(SETTLE);
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          y_d       = core_y;
          done_d    = 1'b1;
          done_id_d = idx_q;
          gnt_d     = '0;
          ptr_d     = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      y_q       <= 1'b0;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= 4'd0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      y_q       <= y_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign y_out   = y_q;
  assign busy    = (state_q == ST_EVAL);

endmodule

// File: tb/tb_lg_eval_arbiter.sv
// Directed bench: main instance with SETTLE=2, second instance with SETTLE=0 for back-to-back service.
module tb_lg_eval_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req_b;
  logic [23:0] opnd, opnd_b;
  logic [3:0]  gnt, gnt_b;
  logic        done, done_b;
  logic [1:0]  done_id, done_id_b;
  logic        y_out, y_b;
  logic        busy, busy_b;

  int total = 0;
  int bad   = 0;

  lg_eval_arbiter #(.N_REQ(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opnd(opnd),
    .gnt(gnt), .done(done), .done_id(done_id), .y_out(y_out), .busy(busy)
  );

  lg_eval_arbiter #(.N_REQ(4), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .opnd(opnd_b),
    .gnt(gnt_b), .done(done_b), .done_id(done_id_b), .y_out(y_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected order/results for the four-way contention step
  logic [3:0] exp_y4 = 4'b1101;   // bit k = y for requester k

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    req_b  = '0;
    opnd   = '0;
    opnd_b = '0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_id", done_id, 0);
    chk("rst_y", y_out, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    $display("reset checked");

    // Requester 1 alone, 101100 -> y=0
    opnd[6 +: 6] = 6'b101100;
    req = 4'b0010;
    step();
    chk("t1_gnt0", gnt, 4'b0010);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_gnt1", gnt, 4'b0010);
    step();
    chk("t1_gnt2", gnt, 4'b0010);
    chk("t1_nodone", done, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_id", done_id, 1);
    chk("t1_y", y_out, 0);
    chk("t1_gnt_off", gnt, 0);
    chk("t1_busy_off", busy, 0);
    req = '0;
    step();
    chk("t1_pulse", done, 0);
    $display("txn single req1 id=%0d y=%0d", done_id, y_out);

    // Restart from pointer 0 for the contention round
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    opnd = {6'b101110, 6'b111100, 6'b101100, 6'b000000};
    req  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr%0d_gnt", k), gnt, 32'(4'b0001 << k));
      chk($sformatf("rr%0d_nodone", k), done, 0);
      step();
      step();
      step();
      chk($sformatf("rr%0d_done", k), done, 1);
      chk($sformatf("rr%0d_id", k), done_id, k);
      chk($sformatf("rr%0d_y", k), y_out, exp_y4[k]);
      $display("txn rr id=%0d y=%0d", done_id, y_out);
      req[k] = 1'b0;
    end
    step();
    chk("rr_idle", busy, 0);

    // Operand change after grant is ignored (ptr now 0, winner 2)
    opnd[12 +: 6] = 6'b101100;
    req = 4'b0100;
    step();
    chk("t3_gnt", gnt, 4'b0100);
    opnd[12 +: 6] = 6'b000000;
    step();
    step();
    step();
    chk("t3_done", done, 1);
    chk("t3_id", done_id, 2);
    chk("t3_y", y_out, 0);
    $display("txn capture id=%0d y=%0d", done_id, y_out);
    req = '0;

    // Requester 3 drops req mid-evaluation, slice 000000 -> y=1
    opnd[18 +: 6] = 6'b000000;
    req = 4'b1000;
    step();
    chk("t4_gnt", gnt, 4'b1000);
    req = '0;
    step();
    step();
    step();
    chk("t4_done", done, 1);
    chk("t4_id", done_id, 3);
    chk("t4_y", y_out, 1);
    $display("txn drop id=%0d y=%0d", done_id, y_out);
    step();
    chk("t4_nogrant", gnt, 0);
    step();
    chk("t4_nobusy", busy, 0);

    // Serve requester 1 (y=1) so ptr=2, then reset during requester 2's evaluation
    opnd[6 +: 6] = 6'b000000;
    req = 4'b0010;
    step();
    step();
    step();
    step();
    chk("t5_pre_done", done, 1);
    chk("t5_pre_id", done_id, 1);
    chk("t5_pre_y", y_out, 1);
    req = 4'b0100;
    step();
    chk("t5_gnt2", gnt, 4'b0100);
    step();
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_id", done_id, 0);
    chk("t5_rst_y", y_out, 0);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t5_nodone%0d", k), done, 0);
    end
    req = 4'b0111;
    step();
    chk("t5_from0", gnt, 4'b0001);
    step();
    step();
    step();
    chk("t5_done", done, 1);
    chk("t5_id", done_id, 0);
    $display("txn after_reset id=%0d y=%0d", done_id, y_out);
    req = '0;

    // SETTLE=0: requester 0 held continuously, 101100 -> y=0
    opnd_b[5:0] = 6'b101100;
    req_b = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("s0_gnt%0d", k), gnt_b, 4'b0001);
      chk($sformatf("s0_gap%0d", k), done_b, 0);
      step();
      chk($sformatf("s0_done%0d", k), done_b, 1);
      chk($sformatf("s0_id%0d", k), done_id_b, 0);
      chk($sformatf("s0_y%0d", k), y_b, 0);
      chk($sformatf("s0_gntoff%0d", k), gnt_b, 0);
      $display("txn settle0 id=%0d y=%0d", done_id_b, y_b);
    end
    req_b = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
